// File: rtl/frame_loader_pkg.sv
// Shared geometry, widths and state encoding for the frame loader and panel driver.
package frame_loader_pkg;

    localparam int unsigned COLS      = 64;
    localparam int unsigned ROWS      = 32;
    localparam int unsigned HALF_ROWS = 16;
    localparam int unsigned PIX_W     = 24;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned FRAME_PIX = COLS * ROWS;
    localparam int unsigned CNT_W     = $clog2(FRAME_PIX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SWAP = 2'd2
    } state_e;

    // Half-RAM address: buffer bit on top, row within the half and column below.
    function automatic logic [ADDR_W-1:0] ram_addr(input logic bsel, input logic [CNT_W-1:0] idx);
        return {bsel, idx[CNT_W-2:0]};
    endfunction

    function automatic logic in_lower_half(input logic [CNT_W-1:0] idx);
        return idx >= CNT_W'(HALF_ROWS * COLS);
    endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Pixel stream, RAM write port and buffer-handover signals of the frame loader.
interface frame_loader_if;

    logic                                  pix_valid;
    logic                                  pix_sof;
    logic [frame_loader_pkg::PIX_W-1:0]    pix_data;
    logic                                  pix_ready;
    logic [frame_loader_pkg::ADDR_W-1:0]   wr_addr;
    logic [frame_loader_pkg::PIX_W-1:0]    wr_data;
    logic                                  wr_en_hi;
    logic                                  wr_en_lo;
    logic                                  selected_buffer;
    logic                                  actual_buffer;
    logic                                  frame_done;
    logic                                  sync_err;

    modport slave (
        input  pix_valid, pix_sof, pix_data, actual_buffer,
        output pix_ready, wr_addr, wr_data, wr_en_hi, wr_en_lo,
               selected_buffer, frame_done, sync_err
    );

    modport master (
        output pix_valid, pix_sof, pix_data, actual_buffer,
        input  pix_ready, wr_addr, wr_data, wr_en_hi, wr_en_lo,
               selected_buffer, frame_done, sync_err
    );

endinterface

// File: rtl/frame_loader_raster_counter.sv
// Raster position counter {row, col}; wrap_o flags the last pixel of the frame.
module raster_counter
    import frame_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_one_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        count_d = count_q;
        if (load_one_i) begin
            count_d = CNT_W'(1);
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
        wrap_d = (count_d == CNT_W'(FRAME_PIX - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/frame_loader.sv
// Loads a 64x32 raster into the back buffer of a split-RAM double-buffered panel
// and hands the finished buffer over to the panel driver.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter bit WAIT_SWAP = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    frame_loader_if.slave  bus
);

    state_e              state_q, state_d;
    logic                wbuf_q, wbuf_d;
    logic                ready_q, ready_d;
    logic                we_hi_q, we_hi_d;
    logic                we_lo_q, we_lo_d;
    logic                sel_q, sel_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PIX_W-1:0]    data_q, data_d;

    logic                accept_c, swap_hit_c, load_one_c, inc_c, write_c;
    logic [CNT_W-1:0]    idx_c, count;
    logic                wrap;

    assign accept_c   = bus.pix_valid & ready_q;
    assign swap_hit_c = (bus.actual_buffer == sel_q);

    raster_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_one_i (load_one_c),
        .inc_i      (inc_c),
        .count_o    (count),
        .wrap_o     (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c && bus.pix_sof) state_d = ST_LOAD;
            ST_LOAD: if (accept_c && !bus.pix_sof && wrap) state_d = WAIT_SWAP ? ST_SWAP : ST_IDLE;
            ST_SWAP: if (swap_hit_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // An SOF always restarts at pixel 0; the buffer is only re-chosen from IDLE.
    always_comb begin
        wbuf_d     = wbuf_q;
        sel_d      = sel_q;
        err_d      = err_q;
        done_d     = 1'b0;
        ready_d    = (state_d != ST_SWAP);
        load_one_c = 1'b0;
        inc_c      = 1'b0;
        write_c    = 1'b0;
        idx_c      = count;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (bus.pix_sof) begin
                        write_c    = 1'b1;
                        wbuf_d     = ~bus.actual_buffer;
                        load_one_c = 1'b1;
                        idx_c      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    write_c = 1'b1;
                    if (bus.pix_sof) begin
                        err_d      = 1'b1;
                        load_one_c = 1'b1;
                        idx_c      = '0;
                    end else begin
                        inc_c = 1'b1;
                        if (wrap) begin
                            sel_d  = wbuf_q;
                            done_d = !WAIT_SWAP;
                        end
                    end
                end
            end
            ST_SWAP: done_d = swap_hit_c;
            default: ;
        endcase
        we_hi_d = write_c & ~in_lower_half(idx_c);
        we_lo_d = write_c &  in_lower_half(idx_c);
        addr_d  = write_c ? ram_addr(wbuf_d, idx_c) : addr_q;
        data_d  = write_c ? bus.pix_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wbuf_q  <= 1'b0;
            ready_q <= 1'b0;
            we_hi_q <= 1'b0;
            we_lo_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wbuf_q  <= wbuf_d;
            ready_q <= ready_d;
            we_hi_q <= we_hi_d;
            we_lo_q <= we_lo_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.pix_ready       = ready_q;
    assign bus.wr_en_hi        = we_hi_q;
    assign bus.wr_en_lo        = we_lo_q;
    assign bus.wr_addr         = addr_q;
    assign bus.wr_data         = data_q;
    assign bus.selected_buffer = sel_q;
    assign bus.frame_done      = done_q;
    assign bus.sync_err        = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed vector table plus hand-written frame sequences for frame_loader (WAIT_SWAP=1).
module tb_frame_loader;
    import frame_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_loader_if bus ();

    frame_loader #(.WAIT_SWAP(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int wr_cnt = 0;
    int sel_toggles = 0;
    logic sel_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if ((bus.wr_en_hi | bus.wr_en_lo) === 1'b1) wr_cnt++;
        if (bus.selected_buffer !== sel_prev) sel_toggles++;
        sel_prev = bus.selected_buffer;
    end

    typedef struct {
        logic        rst;
        logic        valid;
        logic        sof;
        logic [23:0] data;
        logic [1:0]  we;
        logic [10:0] addr;
        logic        err;
        logic        ready;
        string       name;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic v, input logic s, input logic [23:0] d,
                                 input logic [1:0] we, input logic [10:0] a, input logic e,
                                 input logic rdy, input string n);
        vec_t x;
        x.rst = r; x.valid = v; x.sof = s; x.data = d; x.we = we;
        x.addr = a; x.err = e; x.ready = rdy; x.name = n;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected {hi, lo, addr, data} for frame pixel idx written into buffer b.
    function automatic logic [36:0] wexp(input logic b, input int idx, input logic [23:0] d);
        logic [10:0] i;
        i = 11'(idx);
        return {~i[10], i[10], b, i[9:0], d};
    endfunction

    task automatic send(input logic sof, input logic [23:0] d, input logic b, input int idx, input int gap);
        int w;
        for (int g = 0; g < gap; g++) begin
            bus.pix_valid = 1'b0;
            cyc();
            check("gap_strobe", {bus.wr_en_hi, bus.wr_en_lo}, 2'b00);
        end
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_data  = d;
        w = 0;
        while (!bus.pix_ready && w < 100) begin
            cyc();
            w++;
        end
        if (!bus.pix_ready) begin
            check("ready_timeout", bus.pix_ready, 1);
            bus.pix_valid = 1'b0;
            return;
        end
        cyc();
        check($sformatf("write_px%0d", idx), {bus.wr_en_hi, bus.wr_en_lo, bus.wr_addr, bus.wr_data},
              wexp(b, idx, d));
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic stream(input logic b, input int first, input int last, input logic [23:0] xv, input bit rnd);
        for (int i = first; i <= last; i++) begin
            send(i == 0, 24'(i) ^ xv, b, i, rnd ? int'($urandom_range(0, 1)) : 0);
        end
    endtask

    task automatic finish_swap(input logic exp_sel, input logic new_act, input int hold);
        int f0;
        f0 = fd_cnt;
        check("swap_entry", {bus.pix_ready, bus.selected_buffer, bus.frame_done}, {1'b0, exp_sel, 1'b0});
        for (int k = 0; k < hold; k++) begin
            cyc();
            check("swap_wait", {bus.pix_ready, bus.frame_done}, 2'b00);
        end
        bus.actual_buffer = new_act;
        cyc();
        check("swap_done", bus.frame_done, 1);
        cyc();
        check("after_swap", {bus.pix_ready, bus.frame_done}, 2'b10);
        check("done_once", 64'(fd_cnt - f0), 1);
    endtask

    vec_t vt[11];

    initial begin
        int w0, t0;
        logic [1:0]  we_act;
        logic        chk_ad;
        logic [23:0] wd;

        rst = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_sof = 1'b0;
        bus.pix_data = '0;
        bus.actual_buffer = 1'b0;

        vt[0]  = mkv(0, 1, 1, 24'h123456, 2'b00, 11'h000, 0, 0, "rst_hold0");
        vt[1]  = mkv(0, 1, 0, 24'hFEDCBA, 2'b00, 11'h000, 0, 0, "rst_hold1");
        vt[2]  = mkv(1, 0, 0, 24'h000000, 2'b00, 11'h000, 0, 1, "rst_release");
        vt[3]  = mkv(1, 1, 0, 24'hAAAAAA, 2'b00, 11'h000, 1, 1, "idle_nosof0");
        vt[4]  = mkv(1, 1, 0, 24'h555555, 2'b00, 11'h000, 1, 1, "idle_nosof1");
        vt[5]  = mkv(1, 1, 0, 24'h0F0F0F, 2'b00, 11'h000, 1, 1, "idle_nosof2");
        vt[6]  = mkv(1, 0, 0, 24'h000000, 2'b00, 11'h000, 1, 1, "idle_gap");
        vt[7]  = mkv(1, 1, 1, 24'h000000, 2'b10, 11'h400, 1, 1, "sof_px0");
        vt[8]  = mkv(1, 1, 0, 24'h000001, 2'b10, 11'h401, 1, 1, "px1");
        vt[9]  = mkv(1, 0, 0, 24'h000000, 2'b00, 11'h000, 1, 1, "load_gap");
        vt[10] = mkv(1, 1, 0, 24'h000002, 2'b10, 11'h402, 1, 1, "px2");

        for (int i = 0; i < 11; i++) begin
            rst           = vt[i].rst;
            bus.pix_valid = vt[i].valid;
            bus.pix_sof   = vt[i].sof;
            bus.pix_data  = vt[i].data;
            cyc();
            we_act = {bus.wr_en_hi, bus.wr_en_lo};
            chk_ad = (vt[i].we != 2'b00) || !vt[i].rst;
            wd     = (vt[i].we != 2'b00) ? vt[i].data : 24'd0;
            check(vt[i].name,
                  {we_act, chk_ad ? {bus.wr_addr, bus.wr_data} : 35'd0, bus.sync_err, bus.pix_ready,
                   bus.selected_buffer, bus.frame_done},
                  {vt[i].we, chk_ad ? {vt[i].addr, wd} : 35'd0, vt[i].err, vt[i].ready, 2'b00});
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;

        // Rest of the first frame, data = index, into buffer 1.
        stream(1'b1, 3, 1023, 24'h0, 1'b0);
        send(1'b0, 24'd1024, 1'b1, 1024, 0);
        check("row16_lo", {bus.wr_en_hi, bus.wr_en_lo, bus.wr_addr}, {2'b01, 11'h400});
        stream(1'b1, 1025, 2047, 24'h0, 1'b0);
        finish_swap(1'b1, 1'b1, 50);
        check("err_sticky", bus.sync_err, 1);

        // Reset in the middle of a frame, then a fresh frame to buffer 0.
        stream(1'b0, 0, 299, 24'h111111, 1'b0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 24'h777777;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("mid_rst_outputs", {bus.pix_ready, bus.wr_en_hi, bus.wr_en_lo, bus.wr_addr, bus.wr_data,
                                      bus.selected_buffer, bus.frame_done, bus.sync_err}, 64'd0);
        end
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        cyc();
        check("ready_after_rst", bus.pix_ready, 1);
        stream(1'b0, 0, 1499, 24'h222222, 1'b0);
        // Panel adopts buffer 0 early: write buffer stays 0, SWAP exits immediately.
        bus.actual_buffer = 1'b0;
        stream(1'b0, 1500, 2047, 24'h222222, 1'b0);
        check("swap_hit_entry", {bus.pix_ready, bus.selected_buffer, bus.frame_done}, 3'b000);
        cyc();
        check("swap_hit_exit", {bus.pix_ready, bus.frame_done}, 2'b11);
        cyc();
        check("swap_hit_after", bus.frame_done, 0);
        check("err_clean", bus.sync_err, 0);

        // SOF in the middle of a frame into buffer 1.
        t0 = sel_toggles;
        stream(1'b1, 0, 699, 24'h333333, 1'b0);
        check("err_before_resync", bus.sync_err, 0);
        send(1'b1, 24'hABCDEF, 1'b1, 0, 0);
        check("err_after_resync", bus.sync_err, 1);
        stream(1'b1, 1, 2047, 24'h333333, 1'b0);
        finish_swap(1'b1, 1'b1, 5);
        check("sel_toggle_once", 64'(sel_toggles - t0), 1);

        // Random valid gaps into buffer 0.
        w0 = wr_cnt;
        stream(1'b0, 0, 2047, 24'h444444, 1'b1);
        finish_swap(1'b0, 1'b0, 3);
        check("write_count", 64'(wr_cnt - w0), 2048);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

endmodule
